// File: rtl/eth_pkg.sv
// Shared types and constants for the Ethernet transmit framer and the CRC-32 helper.
package eth_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PREAMBLE,
    ST_SFD,
    ST_DATA,
    ST_PAD,
    ST_FCS,
    ST_IFG
  } state_t;

  localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0]  SFD_BYTE      = 8'hD5;
  localparam logic [31:0] CRC_POLY      = 32'hEDB88320;
  localparam logic [31:0] CRC_INIT      = 32'hFFFFFFFF;

  // A corrupted frame sends the raw CRC register instead of its complement.
  function automatic logic [7:0] fcs_byte(input logic [31:0] crc, input logic corrupt,
                                          input logic [1:0] idx);
    logic [31:0] fcs;
    fcs = corrupt ? crc : ~crc;
    return fcs[{idx, 3'b000} +: 8];
  endfunction

endpackage

// File: rtl/eth_tx_framer_if.sv
// Payload input handshake and PHY-side byte stream of the transmit framer.
interface eth_tx_framer_if;
  import eth_pkg::*;

  logic [7:0] i_Data;
  logic       i_Valid;
  logic       i_Last;
  logic       o_Ready;
  logic [7:0] o_Tx_Data;
  logic       o_Tx_En;
  logic       o_Tx_Active;
  logic       o_Done;
  logic       o_Underrun;
  state_t     o_State;

  // A payload byte transfers on a rising edge where i_Valid && o_Ready; i_Data/i_Last
  // must hold while i_Valid is high and o_Ready is low.
  modport slave (
    input  i_Data, i_Valid, i_Last,
    output o_Ready, o_Tx_Data, o_Tx_En, o_Tx_Active, o_Done, o_Underrun, o_State
  );

  modport master (
    output i_Data, i_Valid, i_Last,
    input  o_Ready, o_Tx_Data, o_Tx_En, o_Tx_Active, o_Done, o_Underrun, o_State
  );

endinterface

// File: rtl/eth_crc32.sv
// Byte-wide next-state of the reflected Ethernet CRC-32; shared by the tx framer and rx checker.
module eth_crc32
  import eth_pkg::*;
(
  input  logic [31:0] i_Crc,
  input  logic [7:0]  i_Byte,
  output logic [31:0] o_Crc
);

  always_comb begin
    logic [31:0] c;
    c = i_Crc ^ {24'h000000, i_Byte};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
    end
    o_Crc = c;
  end

endmodule

// File: rtl/eth_tx_framer.sv
// Ethernet transmit framer: preamble, SFD, payload, zero pad, FCS and inter-frame gap
// as a registered byte stream with tx-enable, in the RGMII TX byte-clock domain.
module eth_tx_framer
  import eth_pkg::*;
#(
  parameter int PREAMBLE_BYTES = 7,
  parameter int MIN_FRAME      = 60,
  parameter int MAX_FRAME      = 1514,
  parameter int IFG_BYTES      = 12
) (
  input  logic      i_Clock,
  input  logic      i_Rst_L,
  eth_tx_framer_if.slave bus
);

  localparam logic [10:0] MIN_CNT  = 11'(MIN_FRAME);
  localparam logic [10:0] MAX_CNT  = 11'(MAX_FRAME);
  localparam logic [3:0]  PRE_LAST = 4'(PREAMBLE_BYTES - 1);
  localparam logic [3:0]  IFG_LAST = 4'(IFG_BYTES - 1);

  state_t      state_q;
  logic [10:0] cnt_q;
  logic [3:0]  aux_q;
  logic [31:0] crc_q;
  logic [31:0] crc_d;
  logic        bad_q;
  logic [7:0]  tx_data_q;
  logic        tx_en_q;
  logic        active_q;
  logic        done_q;
  logic        underrun_q;

  logic [10:0] cnt_inc;
  logic [7:0]  crc_in;

  assign cnt_inc = (cnt_q == MAX_CNT) ? cnt_q : cnt_q + 11'd1;
  assign crc_in  = (state_q == ST_PAD) ? 8'h00 : bus.i_Data;

  eth_crc32 u_crc (
    .i_Crc  (crc_q),
    .i_Byte (crc_in),
    .o_Crc  (crc_d)
  );

  always_ff @(posedge i_Clock or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      aux_q      <= '0;
      crc_q      <= CRC_INIT;
      bad_q      <= 1'b0;
      tx_data_q  <= 8'h00;
      tx_en_q    <= 1'b0;
      active_q   <= 1'b0;
      done_q     <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      done_q     <= 1'b0;
      underrun_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          tx_data_q <= 8'h00;
          tx_en_q   <= 1'b0;
          if (bus.i_Valid) begin
            state_q  <= ST_PREAMBLE;
            cnt_q    <= '0;
            aux_q    <= '0;
            crc_q    <= CRC_INIT;
            bad_q    <= 1'b0;
            active_q <= 1'b1;
          end
        end
        ST_PREAMBLE: begin
          tx_data_q <= PREAMBLE_BYTE;
          tx_en_q   <= 1'b1;
          aux_q     <= aux_q + 4'd1;
          if (aux_q == PRE_LAST) state_q <= ST_SFD;
        end
        ST_SFD: begin
          tx_data_q <= SFD_BYTE;
          tx_en_q   <= 1'b1;
          state_q   <= ST_DATA;
        end
        ST_DATA: begin
          tx_en_q <= 1'b1;
          if (bus.i_Valid) begin
            tx_data_q <= bus.i_Data;
            crc_q     <= crc_d;
            cnt_q     <= cnt_inc;
            if (bus.i_Last || cnt_inc == MAX_CNT) begin
              aux_q   <= '0;
              state_q <= (cnt_inc < MIN_CNT) ? ST_PAD : ST_FCS;
            end
          end else begin
            // Starved mid-frame: send a deliberately bad FCS right away so the wire has no bubble.
            underrun_q <= 1'b1;
            bad_q      <= 1'b1;
            tx_data_q  <= fcs_byte(crc_q, 1'b1, 2'd0);
            aux_q      <= 4'd1;
            state_q    <= ST_FCS;
          end
        end
        ST_PAD: begin
          tx_data_q <= 8'h00;
          tx_en_q   <= 1'b1;
          crc_q     <= crc_d;
          cnt_q     <= cnt_inc;
          if (cnt_inc >= MIN_CNT) begin
            aux_q   <= '0;
            state_q <= ST_FCS;
          end
        end
        ST_FCS: begin
          tx_data_q <= fcs_byte(crc_q, bad_q, aux_q[1:0]);
          tx_en_q   <= 1'b1;
          aux_q     <= aux_q + 4'd1;
          if (aux_q == 4'd3) begin
            aux_q   <= '0;
            state_q <= ST_IFG;
          end
        end
        ST_IFG: begin
          tx_data_q <= 8'h00;
          tx_en_q   <= 1'b0;
          aux_q     <= aux_q + 4'd1;
          if (aux_q == IFG_LAST) begin
            done_q   <= 1'b1;
            active_q <= 1'b0;
            state_q  <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.o_Ready     = (state_q == ST_DATA);
  assign bus.o_Tx_Data   = tx_data_q;
  assign bus.o_Tx_En     = tx_en_q;
  assign bus.o_Tx_Active = active_q;
  assign bus.o_Done      = done_q;
  assign bus.o_Underrun  = underrun_q;
  assign bus.o_State     = state_q;

endmodule

// File: tb/tb_eth_tx_framer.sv
// Directed bench for eth_tx_framer: a cycle table on a MIN_FRAME=0 instance and
// scoreboarded frame sequences on a default-parameter instance.
module tb_eth_tx_framer;
  import eth_pkg::*;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] data  = 8'h00;
  logic       valid = 1'b0;
  logic       last  = 1'b0;

  always #4 clk = ~clk;

  eth_tx_framer_if bus0 ();
  eth_tx_framer_if bus1 ();

  assign bus0.i_Data  = data;
  assign bus0.i_Valid = valid;
  assign bus0.i_Last  = last;
  assign bus1.i_Data  = data;
  assign bus1.i_Valid = valid;
  assign bus1.i_Last  = last;

  eth_tx_framer #(.MIN_FRAME(0)) dut0 (.i_Clock(clk), .i_Rst_L(rst_n), .bus(bus0));
  eth_tx_framer                  dut1 (.i_Clock(clk), .i_Rst_L(rst_n), .bus(bus1));

  int checks = 0;
  int errors = 0;

  logic [7:0] exp_q[$];
  logic [7:0] cap_q[$];
  logic [7:0] pay      [0:1599];
  bit         pay_last [0:1599];

  // Monitor on dut1, sampled on the falling edge
  int en_cnt = 0, ur_cnt = 0, done_cnt = 0, acc_cnt = 0, cyc = 0;
  int fall_cyc = 0, last_gap = 0;
  bit prev_en = 1'b0, seen_fall = 1'b0;

  always @(negedge clk) begin
    cyc++;
    if (bus1.o_Tx_En) begin
      cap_q.push_back(bus1.o_Tx_Data);
      en_cnt++;
    end
    if (bus1.o_Underrun) ur_cnt++;
    if (bus1.o_Done) done_cnt++;
    if (valid && bus1.o_Ready) acc_cnt++;
    if (prev_en && !bus1.o_Tx_En) begin
      fall_cyc  = cyc;
      seen_fall = 1'b1;
    end
    if (!prev_en && bus1.o_Tx_En && seen_fall) last_gap = cyc - fall_cyc;
    prev_en = bus1.o_Tx_En;
  end

  int b_en, b_ur, b_done, b_acc, b_cap;

  task automatic mark();
    b_en   = en_cnt;
    b_ur   = ur_cnt;
    b_done = done_cnt;
    b_acc  = acc_cnt;
    b_cap  = cap_q.size();
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: cycle budget expired", name);
  endtask

  function automatic logic [31:0] crc_step(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 8; i++) r = (r >> 1) ^ ((r[0] ^ b[i]) ? 32'hEDB88320 : 32'h0);
    return r;
  endfunction

  task automatic build_exp(input int n, input bit corrupt, input int minf);
    logic [31:0] crc;
    logic [31:0] fcs;
    int cnt;
    exp_q.delete();
    for (int i = 0; i < 7; i++) exp_q.push_back(8'h55);
    exp_q.push_back(8'hD5);
    crc = 32'hFFFFFFFF;
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(pay[i]);
      crc = crc_step(crc, pay[i]);
    end
    cnt = n;
    while (cnt < minf) begin
      exp_q.push_back(8'h00);
      crc = crc_step(crc, 8'h00);
      cnt++;
    end
    fcs = corrupt ? crc : ~crc;
    for (int i = 0; i < 4; i++) exp_q.push_back(fcs[8*i +: 8]);
  endtask

  task automatic check_capture(input string name);
    int n;
    n = cap_q.size() - b_cap;
    chk({name, "_len"}, n, exp_q.size());
    for (int i = 0; i < n && i < exp_q.size(); i++)
      chk($sformatf("%s_byte%0d", name, i), cap_q[b_cap + i], exp_q[i]);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    valid = 1'b0;
    last  = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Presents pay[0..n-1] with pay_last flags; drops i_Valid after n bytes are taken,
  // or on o_Done when stop_on_done is set.
  task automatic drive_frame(input int n, input bit stop_on_done);
    int idx, budget;
    bit took;
    idx    = 0;
    budget = 0;
    data   = pay[0];
    last   = pay_last[0];
    valid  = 1'b1;
    while (valid && budget < 4000) begin
      @(negedge clk);
      took = valid && bus1.o_Ready;
      @(posedge clk);
      #1;
      budget++;
      if (took) begin
        idx++;
        if (idx == n) begin
          valid = 1'b0;
          last  = 1'b0;
        end else begin
          data = pay[idx];
          last = pay_last[idx];
        end
      end
      if (stop_on_done && bus1.o_Done) begin
        valid = 1'b0;
        last  = 1'b0;
      end
    end
    if (valid) begin
      valid = 1'b0;
      timeout_fail("drive_frame");
    end
  endtask

  task automatic wait_done(input int target);
    int b;
    b = 0;
    while ((done_cnt - b_done) < target && b < 300) begin
      @(posedge clk);
      #1;
      b++;
    end
    if ((done_cnt - b_done) < target) timeout_fail("wait_done");
  endtask

  typedef struct {
    logic [7:0] data;
    logic       valid;
    logic       last;
    logic [7:0] exp_data;
    logic       exp_en;
    logic       exp_ready;
    logic       exp_done;
  } vec_t;

  vec_t       vecs [34];
  logic [7:0] fcs_ref [4];

  initial begin
    // Reset held with i_Valid high, then release
    rst_n = 1'b0;
    valid = 1'b1;
    data  = 8'hA5;
    repeat (3) @(negedge clk);
    chk("rst_tx_data", bus1.o_Tx_Data, 8'h00);
    chk("rst_tx_en", bus1.o_Tx_En, 0);
    chk("rst_ready", bus1.o_Ready, 0);
    chk("rst_active", bus1.o_Tx_Active, 0);
    chk("rst_done", bus1.o_Done, 0);
    chk("rst_underrun", bus1.o_Underrun, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("start_state", bus1.o_State, ST_PREAMBLE);
    chk("start_tx_en", bus1.o_Tx_En, 0);
    chk("start_active", bus1.o_Tx_Active, 1);
    @(posedge clk); #1;
    chk("first_pre_data", bus1.o_Tx_Data, 8'h55);
    chk("first_pre_en", bus1.o_Tx_En, 1);
    valid = 1'b0;

    // Cycle table: "123456789" through the MIN_FRAME=0 instance
    fcs_ref = '{8'h26, 8'h39, 8'hF4, 8'hCB};
    for (int k = 1; k <= 34; k++) begin
      vec_t v;
      v.valid     = (k <= 18);
      v.data      = (k <= 10) ? 8'h31 : 8'(8'h31 + k - 10);
      v.last      = (k == 18);
      v.exp_done  = (k == 34);
      v.exp_ready = (k >= 9 && k <= 17);
      v.exp_en    = (k >= 2 && k <= 22);
      if (k == 1 || k >= 23)   v.exp_data = 8'h00;
      else if (k <= 8)         v.exp_data = 8'h55;
      else if (k == 9)         v.exp_data = 8'hD5;
      else if (k <= 18)        v.exp_data = 8'(8'h31 + k - 10);
      else                     v.exp_data = fcs_ref[k - 19];
      vecs[k-1] = v;
    end
    do_reset();
    for (int i = 0; i < 34; i++) begin
      data  = vecs[i].data;
      valid = vecs[i].valid;
      last  = vecs[i].last;
      @(posedge clk); #1;
      chk($sformatf("tbl%0d_data", i+1), bus0.o_Tx_Data, vecs[i].exp_data);
      chk($sformatf("tbl%0d_en", i+1), bus0.o_Tx_En, vecs[i].exp_en);
      chk($sformatf("tbl%0d_ready", i+1), bus0.o_Ready, vecs[i].exp_ready);
      chk($sformatf("tbl%0d_done", i+1), bus0.o_Done, vecs[i].exp_done);
    end

    // Single-byte frame padded to minimum length
    do_reset();
    @(posedge clk); #1;
    mark();
    pay[0] = 8'hAB;
    pay_last[0] = 1'b1;
    drive_frame(1, 1'b0);
    wait_done(1);
    build_exp(1, 1'b0, 60);
    check_capture("pad1");
    chk("pad1_en_cycles", en_cnt - b_en, 72);
    chk("pad1_underrun", ur_cnt - b_ur, 0);

    // Underrun after 20 bytes: inverted FCS, no pad
    do_reset();
    @(posedge clk); #1;
    mark();
    for (int i = 0; i < 20; i++) begin
      pay[i] = 8'($urandom_range(0, 255));
      pay_last[i] = 1'b0;
    end
    drive_frame(20, 1'b0);
    wait_done(1);
    build_exp(20, 1'b1, 0);
    check_capture("urun");
    chk("urun_pulses", ur_cnt - b_ur, 1);
    chk("urun_en_cycles", en_cnt - b_en, 32);
    chk("urun_accepted", acc_cnt - b_acc, 20);

    // 1600-byte stream without i_Last is cut at MAX_FRAME
    do_reset();
    @(posedge clk); #1;
    mark();
    for (int i = 0; i < 1600; i++) begin
      pay[i] = 8'($urandom_range(0, 255));
      pay_last[i] = 1'b0;
    end
    drive_frame(1600, 1'b1);
    wait_done(1);
    build_exp(1514, 1'b0, 0);
    check_capture("max");
    chk("max_accepted", acc_cnt - b_acc, 1514);
    chk("max_en_cycles", en_cnt - b_en, 1526);
    chk("max_underrun", ur_cnt - b_ur, 0);

    // Back-to-back 5-byte frames with i_Valid held high
    do_reset();
    @(posedge clk); #1;
    mark();
    for (int i = 0; i < 10; i++) begin
      pay[i] = 8'(8'h10 + i);
      pay_last[i] = (i == 4 || i == 9);
    end
    drive_frame(10, 1'b0);
    wait_done(2);
    chk("b2b_gap_ge13", (last_gap >= 13), 1);
    chk("b2b_done", done_cnt - b_done, 2);
    chk("b2b_accepted", acc_cnt - b_acc, 10);
    chk("b2b_en_cycles", en_cnt - b_en, 144);

    // Asynchronous reset in the middle of the payload
    do_reset();
    @(posedge clk); #1;
    mark();
    data  = 8'h77;
    last  = 1'b0;
    valid = 1'b1;
    for (int b = 0; b < 100 && (acc_cnt - b_acc) < 3; b++) begin
      @(posedge clk); #1;
    end
    chk("mid_in_data", bus1.o_State, ST_DATA);
    chk("mid_en_before", bus1.o_Tx_En, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_en_async", bus1.o_Tx_En, 0);
    chk("mid_data_async", bus1.o_Tx_Data, 8'h00);
    chk("mid_active_async", bus1.o_Tx_Active, 0);
    chk("mid_state_async", bus1.o_State, ST_IDLE);
    valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
